// File: rtl/pipeline_trace_checker_pkg.sv
// Shared definitions for the pipeline trace checker: stage one-hot indices,
// expectation-mask bit positions and the run-control state encoding.
package pipeline_trace_checker_pkg;

    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

    localparam int MASK_WB    = 0;
    localparam int MASK_MEM   = 1;
    localparam int MASK_VALID = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input int idx);
        stage_onehot = 5'b00001 << idx;
    endfunction

endpackage

// File: rtl/trace_fail_fifo.sv
// Small FIFO of {pc, stage} failure records; drops records when full and
// raises a sticky overflow flag. A push while full succeeds if a pop happens.
module trace_fail_fifo
    import pipeline_trace_checker_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LOG_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  push,
    input  logic [PC_W-1:0]       push_pc,
    input  logic [NUM_STAGES-1:0] push_stage,
    input  logic                  pop_ready,
    output logic                  pop_valid,
    output logic [PC_W-1:0]       pop_pc,
    output logic [NUM_STAGES-1:0] pop_stage,
    output logic                  overflow
);

    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(LOG_DEPTH);

    logic [PC_W+NUM_STAGES-1:0] mem_q [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full_s, pop_s, push_s;

    // Pointer, occupancy and overflow next-state.
    always_comb begin
        full_s   = (cnt_q == FULL_CNT);
        pop_s    = pop_ready && (cnt_q != '0);
        push_s   = push && (!full_s || pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
            ovf_d = ovf_q || (push && !push_s);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Record storage; contents are meaningless while the count is zero.
    always_ff @(posedge clk) begin
        if (push_s && !clr) begin
            mem_q[wr_ptr_q] <= {push_pc, push_stage};
        end
    end

    assign pop_valid             = (cnt_q != '0);
    assign {pop_pc, pop_stage}   = mem_q[rd_ptr_q];
    assign overflow              = ovf_q;

endmodule

// File: rtl/pipeline_trace_checker.sv
// Compares CPU debug taps against a PC-indexed expectation table during a run.
// Optional fail log enabled by defining TRACE_CHECKER_FAIL_LOG_EN.
module pipeline_trace_checker
    import pipeline_trace_checker_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int I_ADDR_WIDTH = 10,
    parameter int R_ADDR_WIDTH = 5,
    parameter int D_ADDR_WIDTH = 7,
    parameter int DEPTH        = 64,
    parameter int CNT_WIDTH    = 16,
    parameter int TIMEOUT      = 255,
    parameter int LOG_DEPTH    = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic                                              cfg_we,
    input  logic [$clog2(DEPTH)-1:0]                          cfg_addr,
    input  logic [3+DATA_WIDTH+R_ADDR_WIDTH+D_ADDR_WIDTH-1:0] cfg_entry,
    input  logic [I_ADDR_WIDTH-1:0]                           end_pc,
    input  logic [NUM_STAGES-1:0]                             dbg_stage,
    input  logic [I_ADDR_WIDTH-1:0]                           dbg_pc,
    input  logic [DATA_WIDTH-1:0]                             dbg_wb_value,
    input  logic                                              dbg_reg_write,
    input  logic [R_ADDR_WIDTH-1:0]                           dbg_rd_addr,
    input  logic [D_ADDR_WIDTH-1:0]                           dbg_bus_address,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic [CNT_WIDTH-1:0]                              pass_count,
    output logic [CNT_WIDTH-1:0]                              fail_count,
    output logic [I_ADDR_WIDTH-1:0]                           first_fail_pc,
    output logic [NUM_STAGES-1:0]                             first_fail_stage
`ifdef TRACE_CHECKER_FAIL_LOG_EN
    ,
    input  logic                                              log_ready,
    output logic                                              log_valid,
    output logic [I_ADDR_WIDTH-1:0]                           log_pc,
    output logic [NUM_STAGES-1:0]                             log_stage,
    output logic                                              log_overflow
`endif
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 3 + DATA_WIDTH + R_ADDR_WIDTH + D_ADDR_WIDTH;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [I_ADDR_WIDTH:0]   DEPTH_L  = (I_ADDR_WIDTH+1)'(DEPTH);

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
        if (sum[CNT_WIDTH]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[CNT_WIDTH-1:0];
        end
    endfunction

    logic [ENTRY_W-1:0] table_q [DEPTH];

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    chk_pass_q, chk_pass_d, chk_fail_q, chk_fail_d, chk_tmo_q, chk_tmo_d;
    logic [I_ADDR_WIDTH-1:0] chk_pc_q, chk_pc_d;
    logic [NUM_STAGES-1:0]   chk_stage_q, chk_stage_d;
    logic [CNT_WIDTH-1:0]    pass_count_q, pass_count_d, fail_count_q, fail_count_d;
    logic                    ff_valid_q, ff_valid_d;
    logic [I_ADDR_WIDTH-1:0] ff_pc_q, ff_pc_d;
    logic [NUM_STAGES-1:0]   ff_stage_q, ff_stage_d;
    logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic [ENTRY_W-1:0]      entry_s;
    logic [2:0]              mask_s;
    logic                    run_s, wb_sample_s, mem_sample_s, chk_en_s;
    logic                    mem_chk_s, wb_chk_s, mem_ok_s, wb_ok_s, tmo_s;
    logic                    enter_run_s, any_fail_s;

    // Expectation table: writable only outside a run, never reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q != ST_RUN)) begin
            table_q[cfg_addr] <= cfg_entry;
        end
    end

    // Sample the taps against the table entry for the current PC.
    always_comb begin
        entry_s      = table_q[dbg_pc[IDX_W-1:0]];
        mask_s       = entry_s[ENTRY_W-1 -: 3];
        run_s        = (state_q == ST_RUN);
        wb_sample_s  = run_s && (dbg_stage == stage_onehot(STG_WB));
        mem_sample_s = run_s && (dbg_stage == stage_onehot(STG_MEM));
        chk_en_s     = ({1'b0, dbg_pc} < DEPTH_L) && mask_s[MASK_VALID];
        mem_chk_s    = mem_sample_s && chk_en_s && mask_s[MASK_MEM];
        wb_chk_s     = wb_sample_s && chk_en_s && mask_s[MASK_WB];
        mem_ok_s     = (dbg_bus_address == entry_s[D_ADDR_WIDTH-1:0]);
        wb_ok_s      = dbg_reg_write
                    && (dbg_wb_value == entry_s[D_ADDR_WIDTH+R_ADDR_WIDTH +: DATA_WIDTH])
                    && (dbg_rd_addr  == entry_s[D_ADDR_WIDTH +: R_ADDR_WIDTH]);
        tmo_s        = run_s && !wb_sample_s && (tmr_q == TMR_LAST);
    end

    // Run control, check pipeline, counters, first-fail record and outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if ((wb_sample_s && (dbg_pc == end_pc)) || tmo_s) state_d = ST_DONE;
                else                                               state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        enter_run_s = (state_q != ST_RUN) && (state_d == ST_RUN);

        if (enter_run_s || wb_sample_s) begin
            tmr_d = '0;
        end else if (run_s) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = tmr_q;
        end

        chk_pass_d  = (mem_chk_s && mem_ok_s) || (wb_chk_s && wb_ok_s);
        chk_fail_d  = (mem_chk_s && !mem_ok_s) || (wb_chk_s && !wb_ok_s);
        chk_tmo_d   = tmo_s;
        chk_pc_d    = dbg_pc;
        chk_stage_d = dbg_stage;

        // A timeout record carries stage 0 unless a real check failed alongside it.
        any_fail_s = chk_fail_q || chk_tmo_q;
        if (enter_run_s) begin
            pass_count_d = '0;
            fail_count_d = '0;
            ff_valid_d   = 1'b0;
            ff_pc_d      = '0;
            ff_stage_d   = '0;
        end else begin
            pass_count_d = sat_add(pass_count_q, {1'b0, chk_pass_q});
            fail_count_d = sat_add(fail_count_q, {chk_fail_q & chk_tmo_q, chk_fail_q ^ chk_tmo_q});
            if (any_fail_s && !ff_valid_q) begin
                ff_valid_d = 1'b1;
                ff_pc_d    = chk_pc_q;
                ff_stage_d = chk_fail_q ? chk_stage_q : 5'b00000;
            end else begin
                ff_valid_d = ff_valid_q;
                ff_pc_d    = ff_pc_q;
                ff_stage_d = ff_stage_q;
            end
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        pass_d = done_d && (fail_count_d == '0) && (pass_count_d != '0);
    end

    // All control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            chk_pass_q   <= 1'b0;
            chk_fail_q   <= 1'b0;
            chk_tmo_q    <= 1'b0;
            chk_pc_q     <= '0;
            chk_stage_q  <= '0;
            pass_count_q <= '0;
            fail_count_q <= '0;
            ff_valid_q   <= 1'b0;
            ff_pc_q      <= '0;
            ff_stage_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            chk_pass_q   <= chk_pass_d;
            chk_fail_q   <= chk_fail_d;
            chk_tmo_q    <= chk_tmo_d;
            chk_pc_q     <= chk_pc_d;
            chk_stage_q  <= chk_stage_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
            ff_valid_q   <= ff_valid_d;
            ff_pc_q      <= ff_pc_d;
            ff_stage_q   <= ff_stage_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign pass_count       = pass_count_q;
    assign fail_count       = fail_count_q;
    assign first_fail_pc    = ff_pc_q;
    assign first_fail_stage = ff_stage_q;

`ifdef TRACE_CHECKER_FAIL_LOG_EN
    trace_fail_fifo #(
        .PC_W      (I_ADDR_WIDTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fail_log (
        .clk        (clk),
        .reset      (reset),
        .clr        (enter_run_s),
        .push       (any_fail_s),
        .push_pc    (chk_pc_q),
        .push_stage (chk_fail_q ? chk_stage_q : 5'b00000),
        .pop_ready  (log_ready),
        .pop_valid  (log_valid),
        .pop_pc     (log_pc),
        .pop_stage  (log_stage),
        .overflow   (log_overflow)
    );
`endif

endmodule

// File: tb/tb_pipeline_trace_checker.sv
// Directed self-checking bench for pipeline_trace_checker (counter width
// reduced to 3 bits so saturation is reachable).
module tb_pipeline_trace_checker;

    localparam int CW = 3;
    localparam logic [4:0] S_IF  = 5'b00001;
    localparam logic [4:0] S_ID  = 5'b00010;
    localparam logic [4:0] S_EX  = 5'b00100;
    localparam logic [4:0] S_MEM = 5'b01000;
    localparam logic [4:0] S_WB  = 5'b10000;

    logic        clk = 1'b0;
    logic        reset, start, cfg_we, dbg_reg_write;
    logic [5:0]  cfg_addr;
    logic [22:0] cfg_entry;
    logic [9:0]  end_pc, dbg_pc, first_fail_pc;
    logic [4:0]  dbg_stage, dbg_rd_addr, first_fail_stage;
    logic [7:0]  dbg_wb_value;
    logic [6:0]  dbg_bus_address;
    logic        busy, done, pass;
    logic [CW-1:0] pass_count, fail_count;
`ifdef TRACE_CHECKER_FAIL_LOG_EN
    logic        log_ready, log_valid, log_overflow;
    logic [9:0]  log_pc;
    logic [4:0]  log_stage;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    pipeline_trace_checker #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_entry(cfg_entry), .end_pc(end_pc), .dbg_stage(dbg_stage), .dbg_pc(dbg_pc),
        .dbg_wb_value(dbg_wb_value), .dbg_reg_write(dbg_reg_write), .dbg_rd_addr(dbg_rd_addr),
        .dbg_bus_address(dbg_bus_address), .busy(busy), .done(done), .pass(pass),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_pc(first_fail_pc), .first_fail_stage(first_fail_stage)
`ifdef TRACE_CHECKER_FAIL_LOG_EN
        , .log_ready(log_ready), .log_valid(log_valid), .log_pc(log_pc),
        .log_stage(log_stage), .log_overflow(log_overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input logic [2:0] m, input int v, input int rd, input int bus);
        cfg_we    = 1'b1;
        cfg_addr  = 6'(a);
        cfg_entry = {m, 8'(v), 5'(rd), 7'(bus)};
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic drive(input logic [4:0] stg, input int pc, input int val, input logic rw,
                         input int rd, input int bus);
        dbg_stage       = stg;
        dbg_pc          = 10'(pc);
        dbg_wb_value    = 8'(val);
        dbg_reg_write   = rw;
        dbg_rd_addr     = 5'(rd);
        dbg_bus_address = 7'(bus);
        tick();
        dbg_stage       = 5'b00000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_entry = 23'd0;
        end_pc = 10'd0; dbg_stage = 5'd0; dbg_pc = 10'd0; dbg_wb_value = 8'd0;
        dbg_reg_write = 1'b0; dbg_rd_addr = 5'd0; dbg_bus_address = 7'd0;
`ifdef TRACE_CHECKER_FAIL_LOG_EN
        log_ready = 1'b0;
`endif
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_pass_count", pass_count, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_ff_pc", first_fail_pc, 0);
        check("rst_ff_stage", first_fail_stage, 0);
        reset = 1'b1;
        tick();

        cfg(0, 3'b101, 10, 29, 0);
        cfg(1, 3'b110, 0, 0, 74);
        cfg(2, 3'b010, 0, 0, 0);
        cfg(3, 3'b110, 0, 0, 74);
        check("idle_busy", busy, 0);

        // WB pass at the final PC
        end_pc = 10'd0;
        pulse_start();
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        drive(S_WB, 0, 10, 1'b1, 29, 0);
        check("last_busy", busy, 0);
        check("done_lag", done, 0);
        check("count_lag", pass_count, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_pass_count", pass_count, 1);
        check("t1_fail_count", fail_count, 0);

        // WB value mismatch
        pulse_start();
        check("restart_clear", pass_count, 0);
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        drive(S_WB, 0, 9, 1'b1, 29, 0);
        tick();
        check("t2_fail_count", fail_count, 1);
        check("t2_pass_count", pass_count, 0);
        check("t2_ff_pc", first_fail_pc, 0);
        check("t2_ff_stage", first_fail_stage, 32'(S_WB));
        check("t2_pass", pass, 0);
        check("t2_done", done, 1);

        // MEM checks, ignored cases, first-fail latch
        end_pc = 10'd3;
        pulse_start();
        check("t3_clear_fail", fail_count, 0);
        check("t3_clear_stage", first_fail_stage, 0);
        cfg(3, 3'b110, 0, 0, 75);
        drive(S_MEM, 1, 0, 1'b0, 0, 74);
        check("t3_latency", pass_count, 0);
        drive(S_IF, 1, 0, 1'b0, 0, 99);
        check("t3_mem_pass", pass_count, 1);
        drive(S_ID, 1, 0, 1'b0, 0, 99);
        drive(S_EX, 1, 0, 1'b0, 0, 99);
        drive(S_MEM, 70, 0, 1'b0, 0, 99);
        drive(S_MEM, 2, 0, 1'b0, 0, 99);
        tick();
        check("t3_ignored_pass", pass_count, 1);
        check("t3_ignored_fail", fail_count, 0);
        drive(S_MEM, 1, 0, 1'b0, 0, 75);
        start = 1'b1;
        drive(S_MEM, 3, 0, 1'b0, 0, 75);
        start = 1'b0;
        tick();
        check("t3_fail_count", fail_count, 2);
        check("t3_start_ignored", pass_count, 1);
        check("t3_busy", busy, 1);
        check("t3_ff_pc", first_fail_pc, 1);
        check("t3_ff_stage", first_fail_stage, 32'(S_MEM));
        drive(S_WB, 3, 0, 1'b0, 0, 0);
        tick();
        check("t3_done", done, 1);
        check("t3_pass", pass, 0);
        check("t3_final_fail", fail_count, 2);

        // Timeout with no WB activity
        end_pc = 10'd5;
        pulse_start();
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 256);
        check("tmo_done", done, 1);
        check("tmo_fail_count", fail_count, 1);
        check("tmo_ff_stage", first_fail_stage, 0);
        check("tmo_pass_count", pass_count, 0);

        // Saturation, reg_write=0 fails, reset mid-run
        pulse_start();
        for (int i = 0; i < 9; i++) drive(S_MEM, 1, 0, 1'b0, 0, 74);
        tick();
        check("sat_pass_count", pass_count, 7);
        drive(S_WB, 0, 10, 1'b0, 29, 0);
        tick();
        check("rw0_fail", fail_count, 1);
        check("rw0_stage", first_fail_stage, 32'(S_WB));
        check("rw0_busy", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass_count", pass_count, 0);
        check("abort_fail_count", fail_count, 0);
        check("abort_ff_stage", first_fail_stage, 0);
        tick(); tick();
        check("abort_idle", busy, 0);

        // Table survives reset
        end_pc = 10'd0;
        pulse_start();
        drive(S_WB, 0, 10, 1'b1, 29, 0);
        tick();
        check("keep_pass_count", pass_count, 1);
        check("keep_pass", pass, 1);
        check("keep_done", done, 1);

`ifdef TRACE_CHECKER_FAIL_LOG_EN
        end_pc = 10'd5;
        pulse_start();
        check("log_empty", log_valid, 0);
        check("log_ovf_clear", log_overflow, 0);
        for (int i = 0; i < 6; i++) drive(S_MEM, (i % 2 == 0) ? 1 : 3, 0, 1'b0, 0, 0);
        tick();
        check("log_fail_count", fail_count, 6);
        check("log_valid", log_valid, 1);
        check("log_overflow", log_overflow, 1);
        check("log_head_pc", log_pc, 1);
        check("log_head_stage", log_stage, 32'(S_MEM));
        log_ready = 1'b1;
        n = 0;
        while (log_valid && n < 10) begin
            tick();
            n++;
        end
        log_ready = 1'b0;
        check("log_records", n, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
